// File: rtl/regfile_access_ctrl_if.sv
// Debug requester bus: register peek/poke request with a one-cycle ack and registered read data.
interface regfile_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wd;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rd;

    modport master (output req, output we, output addr, output wd, input ack, input rd);
    modport slave  (input req, input we, input addr, input wd, output ack, output rd);
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register file sequencer: clears all registers after reset, then passes core traffic through
// and slots debug peek/poke accesses in as single stall cycles.
module regfile_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] core_a1_i,
    input  logic [ADDR_WIDTH-1:0] core_a3_i,
    input  logic [DATA_WIDTH-1:0] core_wd_i,
    input  logic                  core_we_i,
    regfile_access_ctrl_if.slave  dbg,
    output logic [ADDR_WIDTH-1:0] rf_a1_o,
    output logic [ADDR_WIDTH-1:0] rf_a3_o,
    output logic [DATA_WIDTH-1:0] rf_wd3_o,
    output logic                  rf_we3_o,
    input  logic [DATA_WIDTH-1:0] rf_rd1_i,
    output logic                  core_stall_o,
    output logic                  init_done_o
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 2);
    localparam logic [ADDR_WIDTH-1:0] ClrLast = '1;

    typedef enum logic [1:0] {StClear, StRun, StDbg} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  init_done_q, init_done_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StClear;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            ack_q       <= 1'b0;
            rd_q        <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ack_q       <= ack_d;
            rd_q        <= rd_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        ack_d        = 1'b0;
        rd_d         = rd_q;
        init_done_d  = init_done_q;
        rf_a1_o      = core_a1_i;
        rf_a3_o      = core_a3_i;
        rf_wd3_o     = core_wd_i;
        rf_we3_o     = core_we_i;
        core_stall_o = 1'b0;

        unique case (state_q)
            StClear: begin
                rf_a3_o      = clr_cnt_q;
                rf_wd3_o     = '0;
                rf_we3_o     = 1'b1;
                core_stall_o = 1'b1;
                wait_cnt_d   = '0;
                clr_cnt_d    = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ClrLast) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                // The ack cycle is masked: the requester is still dropping its request then.
                if (dbg.req && !ack_q) begin
                    if (wait_cnt_q == WaitW'(MAX_WAIT)) begin
                        state_d    = StDbg;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else if (!dbg.req) begin
                    wait_cnt_d = '0;
                end
            end
            StDbg: begin
                core_stall_o = 1'b1;
                rf_a1_o      = dbg.addr;
                rf_a3_o      = dbg.addr;
                rf_wd3_o     = dbg.wd;
                rf_we3_o     = dbg.we && (dbg.addr != '0);
                rd_d         = rf_rd1_i;
                ack_d        = 1'b1;
                state_d      = StRun;
            end
            default: state_d = StClear;
        endcase

        if (reset_i) begin
            rf_we3_o     = 1'b0;
            core_stall_o = 1'b1;
        end
    end

    assign dbg.ack     = ack_q;
    assign dbg.rd      = rd_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 32x32 register file attached.
module tb_regfile_access_ctrl;

    localparam int unsigned MaxWait = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed;
    logic [4:0]  core_a1, core_a3;
    logic [31:0] core_wd;
    logic        core_we;
    logic [4:0]  rf_a1, rf_a3;
    logic [31:0] rf_wd3, rf_rd1;
    logic        rf_we3, core_stall, init_done;
    logic [31:0] regs [32];

    int checks   = 0;
    int failures = 0;

    regfile_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dbg_if ();

    regfile_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(MaxWait)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .core_a1_i   (core_a1),
        .core_a3_i   (core_a3),
        .core_wd_i   (core_wd),
        .core_we_i   (core_we),
        .dbg         (dbg_if),
        .rf_a1_o     (rf_a1),
        .rf_a3_o     (rf_a3),
        .rf_wd3_o    (rf_wd3),
        .rf_we3_o    (rf_we3),
        .rf_rd1_i    (rf_rd1),
        .core_stall_o(core_stall),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    // Register file model, seeded with non-zero junk so the clear sequence is observable.
    always @(posedge clk) begin
        if (seed) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'hA5A5_0000 | k;
        end else if (rf_we3) begin
            regs[rf_a3] <= rf_wd3;
        end
    end
    assign rf_rd1 = regs[rf_a1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in clear cycle 0; walks all 32 clear cycles and the first RUN cycle.
    task automatic clear_check();
        for (int i = 0; i < 32; i++) begin
            chk("clr_a3", 32'(rf_a3), i);
            chk("clr_we3", 32'(rf_we3), 1);
            chk("clr_wd3", rf_wd3, 0);
            chk("clr_stall", 32'(core_stall), 1);
            chk("clr_init", 32'(init_done), 0);
            chk("clr_ack", 32'(dbg_if.ack), 0);
            step();
        end
        chk("init_done", 32'(init_done), 1);
        chk("run_stall", 32'(core_stall), 0);
    endtask

    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic poke_core);
        dbg_if.we   = we;
        dbg_if.addr = addr;
        dbg_if.wd   = wd;
        dbg_if.req  = 1'b1;
        chk("req_stall", 32'(core_stall), 0);
        for (int k = 1; k <= int'(MaxWait); k++) begin
            step();
            chk("wait_stall", 32'(core_stall), 0);
            chk("wait_ack", 32'(dbg_if.ack), 0);
        end
        step();
        if (poke_core) begin
            core_we = 1'b1;
            core_a3 = 5'd9;
            core_wd = 32'hCAFE_F00D;
            #1;
        end
        chk("dbg_stall", 32'(core_stall), 1);
        chk("dbg_a1", 32'(rf_a1), 32'(addr));
        chk("dbg_a3", 32'(rf_a3), 32'(addr));
        chk("dbg_we3", 32'(rf_we3), 32'(we && (addr != 5'd0)));
        step();
        core_we = 1'b0;
        chk("ack_hi", 32'(dbg_if.ack), 1);
        chk("ack_rd", dbg_if.rd, exp_rd);
        chk("ack_stall", 32'(core_stall), 0);
        dbg_if.req = 1'b0;
        step();
        chk("ack_lo", 32'(dbg_if.ack), 0);
        chk("rd_hold", dbg_if.rd, exp_rd);
    endtask

    initial begin
        reset = 1'b1;
        seed = 1'b1;
        core_a1 = '0; core_a3 = '0; core_wd = '0; core_we = 1'b0;
        dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = '0; dbg_if.wd = '0;
        step();
        seed = 1'b0;
        step();
        chk("rst_we3", 32'(rf_we3), 0);
        chk("rst_stall", 32'(core_stall), 1);
        chk("rst_ack", 32'(dbg_if.ack), 0);
        chk("rst_rd", dbg_if.rd, 0);
        chk("rst_init", 32'(init_done), 0);
        reset = 1'b0;
        #1;
        clear_check();
        for (int i = 0; i < 32; i++) begin
            core_a1 = 5'(i);
            #1;
            chk("cleared", rf_rd1, 0);
        end

        // Core write passes straight through
        core_we = 1'b1; core_a3 = 5'd5; core_wd = 32'hDEAD_BEEF;
        #1;
        chk("core_we3", 32'(rf_we3), 1);
        chk("core_a3", 32'(rf_a3), 5);
        chk("core_wd3", rf_wd3, 32'hDEAD_BEEF);
        chk("core_stall", 32'(core_stall), 0);
        chk("core_ack", 32'(dbg_if.ack), 0);
        step();
        core_we = 1'b0;
        core_a1 = 5'd5;
        #1;
        chk("core_rd5", rf_rd1, 32'hDEAD_BEEF);

        dbg_access(1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);
        dbg_access(1'b1, 5'd7, 32'h1234_5678, 32'h0, 1'b1);
        core_a1 = 5'd9;
        #1;
        chk("core_drop", rf_rd1, 0);
        dbg_access(1'b0, 5'd7, 32'h0, 32'h1234_5678, 1'b0);
        dbg_access(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        dbg_access(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

        // Reset during the DBG cycle: access lost, no ack, clear restarts
        dbg_if.we = 1'b0; dbg_if.addr = 5'd5; dbg_if.req = 1'b1;
        for (int k = 0; k <= int'(MaxWait); k++) step();
        chk("rdbg_stall", 32'(core_stall), 1);
        chk("rdbg_a1", 32'(rf_a1), 5);
        reset = 1'b1;
        #1;
        chk("rdbg_we3", 32'(rf_we3), 0);
        chk("rdbg_ack", 32'(dbg_if.ack), 0);
        step();
        chk("rdbg_ack2", 32'(dbg_if.ack), 0);
        chk("rdbg_init", 32'(init_done), 0);
        reset = 1'b0;
        dbg_if.req = 1'b0;
        #1;
        clear_check();

        // Reset mid-clear at clr_cnt=10
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) step();
        chk("mid_a3", 32'(rf_a3), 10);
        reset = 1'b1;
        #1;
        chk("mid_we3", 32'(rf_we3), 0);
        chk("mid_stall", 32'(core_stall), 1);
        step();
        reset = 1'b0;
        #1;
        clear_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
